ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter DW, default 32, datapath and HI/LO width.
REQ-002 SHALL have parameter IMM_W, default 16, sign-extended memory-offset width taken from inst_i[IMM_W-1:0].
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset rst, synchronous, active-high.
REQ-005 SHALL have ports aluop_i input 8, alusel_i input 3, reg1_i input DW, reg2_i input DW, wd_i input 5, wreg_i input 1, inst_i input 32: decoded instruction from the decode stage.
REQ-006 SHALL have port flush_i  input  1  abort any in-flight multi-cycle op.
REQ-007 SHALL have ports wd_o output 5, wreg_o output 1, wdata_o output DW: writeback request.
REQ-008 SHALL have ports aluop_o output 8, mem_addr_o output DW, reg2_o output DW: memory-stage pass-through.
REQ-009 SHALL have ports hi_o output DW, lo_o output DW: architectural HI/LO contents.
REQ-010 SHALL have ports stallreq_o output 1 (hold pipeline) and ov_o output 1 (ADD/SUB overflow flag).

Function
REQ-011 SHALL compute OR, AND, ADD, SUB, SLT (signed) and SLTU (unsigned) combinationally in the same cycle, results selected by alusel_i (logic/arithmetic/move); unlisted alusel_i gives wdata_o=0.
REQ-012 SHALL, on ADD/SUB two's-complement overflow, drive ov_o=1 and wreg_o=0; otherwise ov_o=0 and wreg_o=wreg_i.
REQ-013 SHALL drive mem_addr_o = reg1_i + sign-extended inst_i[IMM_W-1:0], truncated to DW; aluop_o=aluop_i; reg2_o=reg2_i.
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE, DIVZ.
REQ-015 SHALL leave IDLE only when aluop_i is MULT/MULTU (to MUL) or DIV/DIVU (to DIV, or to DIVZ if reg2_i==0); this is the accept cycle T.
REQ-016 SHALL, for signed ops, capture operand magnitudes and result signs at T; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
REQ-017 SHALL run MUL as radix-2 shift-add and DIV as restoring shift-subtract, one bit per cycle, DW iterations on cycles T+1..T+DW, using a log2(DW)+1 bit counter.
REQ-018 SHALL enter DONE at T+DW+1 and write HI/LO at the end of DONE: MUL -> {HI,LO} = 2*DW-bit product; DIV -> HI=remainder, LO=quotient.
REQ-019 SHALL assert stallreq_o combinationally from T through T+DW inclusive and deassert it in DONE; DONE returns to IDLE unconditionally, so the held instruction is not restarted.
REQ-020 SHALL, in DIVZ, stall exactly one cycle (T), leave HI/LO unchanged, return to IDLE.
REQ-021 SHALL, on flush_i=1 in any state, go to IDLE next cycle, leave HI/LO unchanged, deassert stallreq_o in the same cycle.
REQ-022 SHALL write HI/LO directly (single cycle) on MTHI/MTLO from reg1_i when in IDLE.
REQ-023 SHALL return HI/LO on MFHI/MFLO via wdata_o, forwarding the value being written that same cycle (DONE or MTHI/MTLO).
REQ-024 SHALL drive wreg_o=0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set FSM=IDLE, counter=0, HI=LO=0, working registers=0; an op in flight is discarded.
REQ-026 SHALL force stallreq_o=0, wreg_o=0, wdata_o=0, ov_o=0 combinationally while rst=1.

Configuration
REQ-027 SHALL, with EX_MULDIV_DIV_EN defined, implement DIV/DIVU and DIVZ as above.
REQ-028 SHALL, without EX_MULDIV_DIV_EN, omit divider datapath and DIV/DIVZ states; DIV/DIVU act as no-ops (no stall, HI/LO unchanged, wreg_o=0).

Structure
REQ-029 SHALL take aluop/alusel encodings, ZeroWord, RstEnable and WriteEnable/Disable constants from the shared defines package; FSM state encodings local.
REQ-030 SHALL isolate the iterative engine in one sub-module muldiv_iter (start, signed, op, a, b, flush -> busy, done, hi, lo).

Verification
REQ-031 SHALL test ADD 0x7FFFFFFF+1 -> ov_o=1, wreg_o=0; SUB 5-7 -> wdata_o=0xFFFFFFFE, wreg_o=1.
REQ-032 SHALL test MULT -3*7 -> stallreq_o high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 SHALL test DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> LO=0x0FFFFFFF, HI=0xF.
REQ-034 SHALL test DIV x/0 -> 1-cycle stall, HI/LO unchanged.
REQ-035 SHALL test flush_i at T+10 of MULTU -> stallreq_o low that cycle, IDLE next, HI/LO unchanged; also rst at T+5 -> HI=LO=0.
REQ-036 SHALL test MTLO 0x1234 immediately followed by MFLO -> wdata_o=0x1234; repeat with EX_MULDIV_DIV_EN undefined, DIV -> no stall.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared decode constants for the EX stage: aluop/alusel encodings, reset and
// write-enable levels, and the operation selector for the iterative engine.
package ex_muldiv_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000,
                         EXE_AND_OP   = 8'b0010_0100,
                         EXE_OR_OP    = 8'b0010_0101,
                         EXE_ADD_OP   = 8'b0010_0000,
                         EXE_SUB_OP   = 8'b0010_0010,
                         EXE_SLT_OP   = 8'b0010_1010,
                         EXE_SLTU_OP  = 8'b0010_1011,
                         EXE_MFHI_OP  = 8'b0001_0000,
                         EXE_MTHI_OP  = 8'b0001_0001,
                         EXE_MFLO_OP  = 8'b0001_0010,
                         EXE_MTLO_OP  = 8'b0001_0011,
                         EXE_MULT_OP  = 8'b0001_1000,
                         EXE_MULTU_OP = 8'b0001_1001,
                         EXE_DIV_OP   = 8'b0001_1010,
                         EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000,
                         EXE_RES_LOGIC = 3'b001,
                         EXE_RES_MOVE  = 3'b011,
                         EXE_RES_ARITH = 3'b100;

  typedef enum logic {MD_MUL = 1'b0, MD_DIV = 1'b1} md_op_t;

  // Ops whose only architectural effect is on HI/LO, never on the GPR file.
  function automatic logic no_writeback(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) || (op == EXE_DIV_OP) ||
           (op == EXE_DIVU_OP) || (op == EXE_MTHI_OP) || (op == EXE_MTLO_OP);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle engine; shift-add multiply and (with
// EX_MULDIV_DIV_EN defined) restoring divide on operand magnitudes.
module muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sign_op,
  input  md_op_t        op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic          idle,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic [2:0]    state_dbg
);

  localparam int CW = $clog2(DW) + 1;

`ifdef EX_MULDIV_DIV_EN
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2,
                            S_DONE = 3'd3, S_DIVZ = 3'd4} state_t;
`else
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_MUL = 3'd1, S_DONE = 3'd3} state_t;
`endif

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] p_hi, p_lo, opb;
  logic          neg_lo;
  logic          a_neg, b_neg, last;
  logic [DW-1:0] a_mag, b_mag;
  logic [DW:0]   mul_sum;
  logic [2*DW-1:0] prod;
`ifdef EX_MULDIV_DIV_EN
  logic          neg_hi, is_div;
  logic [DW:0]   div_shift, div_diff;
`endif

  assign a_neg = sign_op && a[DW-1];
  assign b_neg = sign_op && b[DW-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign last  = (cnt == CW'(DW - 1));

  assign idle      = (state == S_IDLE);
  assign done      = (state == S_DONE);
`ifdef EX_MULDIV_DIV_EN
  assign busy      = (state == S_MUL) || (state == S_DIV);
`else
  assign busy      = (state == S_MUL);
`endif
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
`ifdef EX_MULDIV_DIV_EN
          if (op == MD_DIV) state_nx = (b == '0) ? S_DIVZ : S_DIV;
          else              state_nx = S_MUL;
`else
          state_nx = S_MUL;
`endif
        end
        S_MUL:  if (last) state_nx = S_DONE;
`ifdef EX_MULDIV_DIV_EN
        S_DIV:  if (last) state_nx = S_DONE;
        S_DIVZ: state_nx = S_IDLE;
`endif
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
`ifdef EX_MULDIV_DIV_EN
    div_shift = {p_hi, p_lo[DW-1]};
    div_diff  = div_shift - {1'b0, opb};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      opb    <= '0;
      neg_lo <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
      neg_hi <= 1'b0;
      is_div <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (idle && start && !flush) begin
        cnt    <= '0;
        p_hi   <= '0;
        p_lo   <= a_mag;
        opb    <= b_mag;
        neg_lo <= a_neg ^ b_neg;
`ifdef EX_MULDIV_DIV_EN
        neg_hi <= (op == MD_DIV) ? a_neg : (a_neg ^ b_neg);
        is_div <= (op == MD_DIV);
`endif
      end else if (busy && !flush) begin
        cnt <= cnt + 1'b1;
`ifdef EX_MULDIV_DIV_EN
        if (is_div) begin
          // Restore by simply not taking the difference when it went negative.
          p_hi <= div_diff[DW] ? div_shift[DW-1:0] : div_diff[DW-1:0];
          p_lo <= {p_lo[DW-2:0], ~div_diff[DW]};
        end else begin
          p_hi <= mul_sum[DW:1];
          p_lo <= {mul_sum[0], p_lo[DW-1:1]};
        end
`else
        p_hi <= mul_sum[DW:1];
        p_lo <= {mul_sum[0], p_lo[DW-1:1]};
`endif
      end
    end
  end

  always_comb begin
    prod = neg_lo ? -{p_hi, p_lo} : {p_hi, p_lo};
    hi   = prod[2*DW-1:DW];
    lo   = prod[DW-1:0];
`ifdef EX_MULDIV_DIV_EN
    if (is_div) begin
      hi = neg_hi ? -p_hi : p_hi;
      lo = neg_lo ? -p_lo : p_lo;
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX stage with single-cycle ALU, HI/LO registers and an iterative
// multiplier; the divider and DIVZ path exist only with EX_MULDIV_DIV_EN.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int IMM_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    aluop_i,
  input  logic [2:0]    alusel_i,
  input  logic [DW-1:0] reg1_i,
  input  logic [DW-1:0] reg2_i,
  input  logic [4:0]    wd_i,
  input  logic          wreg_i,
  input  logic [31:0]   inst_i,
  input  logic          flush_i,
  output logic [4:0]    wd_o,
  output logic          wreg_o,
  output logic [DW-1:0] wdata_o,
  output logic [7:0]    aluop_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] reg2_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          stallreq_o,
  output logic          ov_o,
  output logic [2:0]    dbg_state
);

  // Flow control: while stallreq_o is high the pipeline holds this
  // instruction on the inputs; the cycle it drops, EX outputs are final.
  logic          in_rst, is_mul, is_div, start_req, sign_op;
  md_op_t        md_op;
  logic          it_busy, it_done, it_idle;
  logic [DW-1:0] it_hi, it_lo, hi_q, lo_q, hi_fwd, lo_fwd;
  logic          done_we, mthi_we, mtlo_we;
  logic [DW-1:0] sum, diff, logic_res, arith_res, move_res, result;
  logic          ov;

  assign in_rst = (rst == RstEnable);
  assign is_mul = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
`ifdef EX_MULDIV_DIV_EN
  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
`else
  assign is_div = 1'b0;
`endif
  assign start_req = is_mul || is_div;
  assign sign_op   = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_DIV_OP);
  assign md_op     = is_div ? MD_DIV : MD_MUL;

  muldiv_iter #(.DW(DW)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (start_req),
    .sign_op   (sign_op),
    .op        (md_op),
    .a         (reg1_i),
    .b         (reg2_i),
    .flush     (flush_i),
    .busy      (it_busy),
    .done      (it_done),
    .idle      (it_idle),
    .hi        (it_hi),
    .lo        (it_lo),
    .state_dbg (dbg_state)
  );

  assign stallreq_o = !in_rst && !flush_i && ((it_idle && start_req) || it_busy);

  assign done_we = it_done && !flush_i;
  assign mthi_we = it_idle && !flush_i && (aluop_i == EXE_MTHI_OP);
  assign mtlo_we = it_idle && !flush_i && (aluop_i == EXE_MTLO_OP);

  always_ff @(posedge clk) begin
    if (in_rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done_we) begin
      hi_q <= it_hi;
      lo_q <= it_lo;
    end else begin
      if (mthi_we) hi_q <= reg1_i;
      if (mtlo_we) lo_q <= reg1_i;
    end
  end

  // MFHI/MFLO see the value being committed this cycle, not the stale one.
  always_comb begin
    hi_fwd = done_we ? it_hi : (mthi_we ? reg1_i : hi_q);
    lo_fwd = done_we ? it_lo : (mtlo_we ? reg1_i : lo_q);
  end

  always_comb begin
    sum  = reg1_i + reg2_i;
    diff = reg1_i - reg2_i;
    ov   = ((aluop_i == EXE_ADD_OP) && (reg1_i[DW-1] == reg2_i[DW-1]) &&
            (sum[DW-1] != reg1_i[DW-1])) ||
           ((aluop_i == EXE_SUB_OP) && (reg1_i[DW-1] != reg2_i[DW-1]) &&
            (diff[DW-1] != reg1_i[DW-1]));

    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      default:    logic_res = '0;
    endcase

    arith_res = '0;
    case (aluop_i)
      EXE_ADD_OP:  arith_res = sum;
      EXE_SUB_OP:  arith_res = diff;
      EXE_SLT_OP:  arith_res = {{(DW-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {{(DW-1){1'b0}}, (reg1_i < reg2_i)};
      default:     arith_res = '0;
    endcase

    move_res = '0;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_fwd;
      EXE_MFLO_OP: move_res = lo_fwd;
      default:     move_res = '0;
    endcase

    result = DW'(ZeroWord);
    case (alusel_i)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_ARITH: result = arith_res;
      EXE_RES_MOVE:  result = move_res;
      default:       result = DW'(ZeroWord);
    endcase
  end

  assign wd_o       = wd_i;
  assign aluop_o    = aluop_i;
  assign reg2_o     = reg2_i;
  assign mem_addr_o = reg1_i + {{(DW-IMM_W){inst_i[IMM_W-1]}}, inst_i[IMM_W-1:0]};
  assign ov_o       = !in_rst && ov;
  assign wreg_o     = (in_rst || ov || no_writeback(aluop_i)) ? WriteDisable : wreg_i;
  assign wdata_o    = in_rst ? DW'(ZeroWord) : result;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases then random ops,
// checked against an arithmetic reference model of the EX stage and HI/LO.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = EXE_NOP_OP;
  logic [2:0]  alusel_i = EXE_RES_NOP;
  logic [31:0] reg1_i = '0, reg2_i = '0, inst_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, ov_o;
  logic [31:0] wdata_o, mem_addr_o, reg2_o, hi_o, lo_o;
  logic [7:0]  aluop_o;
  logic [2:0]  dbg_state;

  ex_muldiv #(.DW(32), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .inst_i(inst_i), .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .aluop_o(aluop_o), .mem_addr_o(mem_addr_o),
    .reg2_o(reg2_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o),
    .ov_o(ov_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wdata;
    logic        wreg;
    logic        ov;
    logic [4:0]  wd;
    logic [31:0] maddr;
    logic [31:0] reg2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  stall;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0, m_lo = '0;
  int          checks = 0, failures = 0;
  bit          ins_valid = 1'b0, hl_pend = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] pend_hi, pend_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  // Reference model: what the instruction should do architecturally.
  task automatic model(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst,
                       input logic [4:0] wd, input logic wr, input int kill_at,
                       input bit kill_rst, input bit in_rst);
    longint sa, sb, ua, ub, full;
    logic [63:0] p;
    logic [31:0] lr, ar, mr, res, nh, nl;
    bit ov, nowb;
    int st;
    exp_t e;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    lr = '0; ar = '0; mr = '0; ov = 1'b0; st = 0; nh = m_hi; nl = m_lo;
    nowb = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) || (op == EXE_DIV_OP) ||
           (op == EXE_DIVU_OP) || (op == EXE_MTHI_OP) || (op == EXE_MTLO_OP);
    case (op)
      EXE_OR_OP:   lr = a | b;
      EXE_AND_OP:  lr = a & b;
      EXE_ADD_OP:  begin full = sa + sb; ar = full[31:0];
                     ov = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      EXE_SUB_OP:  begin full = sa - sb; ar = full[31:0];
                     ov = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      EXE_SLT_OP:  ar = (sa < sb) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: ar = (ua < ub) ? 32'd1 : 32'd0;
      EXE_MFHI_OP: mr = m_hi;
      EXE_MFLO_OP: mr = m_lo;
      EXE_MTHI_OP: nh = a;
      EXE_MTLO_OP: nl = a;
      EXE_MULT_OP:  begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; st = 33; end
      EXE_MULTU_OP: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; st = 33; end
      EXE_DIV_OP: begin
`ifdef EX_MULDIV_DIV_EN
        if (b == 0) st = 1;
        else begin st = 33; full = sa / sb; nl = full[31:0]; full = sa % sb; nh = full[31:0]; end
`endif
      end
      EXE_DIVU_OP: begin
`ifdef EX_MULDIV_DIV_EN
        if (b == 0) st = 1;
        else begin st = 33; full = ua / ub; nl = full[31:0]; full = ua % ub; nh = full[31:0]; end
`endif
      end
      default: ;
    endcase
    res = (sel == EXE_RES_LOGIC) ? lr : (sel == EXE_RES_ARITH) ? ar :
          (sel == EXE_RES_MOVE) ? mr : 32'd0;
    e.wdata = res;
    e.wreg  = (ov || nowb) ? 1'b0 : wr;
    e.ov    = ov;
    if (kill_at >= 0) begin
      st = kill_at; nh = m_hi; nl = m_lo;
      if (kill_rst) begin nh = '0; nl = '0; e.wdata = '0; e.wreg = 1'b0; e.ov = 1'b0; end
    end
    if (in_rst) begin
      st = 0; nh = '0; nl = '0; e.wdata = '0; e.wreg = 1'b0; e.ov = 1'b0;
    end
    e.wd    = wd;
    e.maddr = a + 32'(int'($signed(inst[15:0])));
    e.reg2  = b;
    e.hi    = nh;
    e.lo    = nl;
    e.stall = 8'(st);
    m_hi = nh; m_lo = nl;
    exp_q.push_back(e);
  endtask

  // Presents one instruction and holds it until the DUT stops stalling.
  task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst,
                       input logic wr, input int kill_at, input bit kill_rst, input bit in_rst);
    int cyc;
    logic [4:0] wd;
    wd = 5'($urandom_range(0, 31));
    model(op, sel, a, b, inst, wd, wr, kill_at, kill_rst, in_rst);
    @(posedge clk); #1;
    rst = in_rst; flush_i = 1'b0;
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; inst_i = inst;
    wd_i = wd; wreg_i = wr; ins_valid = 1'b1;
    cyc = 0;
    forever begin
      if (kill_at >= 0 && cyc == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else flush_i = 1'b1;
      end
      @(negedge clk);
      if (!stallreq_o) break;
      cyc++;
      if (cyc > 100) begin
        failures++;
        $display("FAIL stall_timeout: actual=%0d cycles expected<=33", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "stall never released");
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic op2(input logic [7:0] op, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] b);
    issue(op, sel, a, b, 32'($urandom_range(0, 65535)), 1'b1, -1, 1'b0, 1'b0);
  endtask

  // Monitor: the cycle stallreq_o is low the EX outputs belong to the head
  // of the expected queue; HI/LO are checked one cycle later.
  always @(negedge clk) begin
    if (hl_pend) begin
      chk("hi", hi_o, pend_hi);
      chk("lo", lo_o, pend_lo);
      hl_pend = 1'b0;
    end
    if (ins_valid) begin
      if (stallreq_o) begin
        stall_cnt++;
      end else if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: actual=retire expected=empty queue");
      end else begin
        mon_e = exp_q.pop_front();
        chk("wdata", wdata_o, mon_e.wdata);
        chk("wreg", 32'(wreg_o), 32'(mon_e.wreg));
        chk("ov", 32'(ov_o), 32'(mon_e.ov));
        chk("wd", 32'(wd_o), 32'(mon_e.wd));
        chk("mem_addr", mem_addr_o, mon_e.maddr);
        chk("reg2", reg2_o, mon_e.reg2);
        chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
        stall_cnt = 0;
        pend_hi = mon_e.hi; pend_lo = mon_e.lo; hl_pend = 1'b1;
      end
    end
  end

  localparam logic [7:0] R_OPS [14] = '{EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP,
    EXE_OR_OP, EXE_AND_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP,
    EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
  localparam logic [2:0] R_SEL [14] = '{EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
    EXE_RES_ARITH, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_NOP,
    EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP};
  localparam logic [31:0] EDGES [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    int idx, kill;
    logic [31:0] a, b;
    logic [2:0] sel;
    repeat (3) @(posedge clk);
    // Reset state: outputs forced low, no stall, HI/LO zero.
    issue(EXE_ADD_OP, EXE_RES_ARITH, 32'd5, 32'd7, 32'h0000_0010, 1'b1, -1, 1'b0, 1'b1);
    issue(EXE_MULT_OP, EXE_RES_NOP, 32'd3, 32'd7, 32'h0, 1'b0, -1, 1'b0, 1'b1);
    // Overflow and basic arithmetic.
    op2(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1);
    op2(EXE_SUB_OP, EXE_RES_ARITH, 32'd5, 32'd7);
    op2(EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h1);
    op2(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1);
    op2(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1);
    op2(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F);
    op2(EXE_AND_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0);
    op2(EXE_ADD_OP, 3'b111, 32'd1, 32'd2);
    // Multiply and divide corner cases.
    op2(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFD, 32'd7);
    op2(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    op2(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    op2(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2);
    op2(EXE_DIVU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h10);
    op2(EXE_DIV_OP, EXE_RES_NOP, 32'd1234, 32'd0);
    op2(EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF);
    // Flush at T+10 of MULTU, then a MULT to show the engine is idle again.
    issue(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 10, 1'b0, 1'b0);
    op2(EXE_MULT_OP, EXE_RES_NOP, 32'h8000_0000, 32'h8000_0000);
    // Reset at T+5 clears HI/LO.
    op2(EXE_MTHI_OP, EXE_RES_NOP, 32'hABCD_0001, 32'h0);
    issue(EXE_MULT_OP, EXE_RES_NOP, 32'd9, 32'd9, 32'h0, 1'b0, 5, 1'b1, 1'b0);
    // MTLO then MFLO back to back.
    op2(EXE_MTLO_OP, EXE_RES_NOP, 32'h0000_1234, 32'h0);
    op2(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    op2(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    // Random ops with edge-value operands and occasional flushes.
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 13);
      a = ($urandom_range(0, 3) == 0) ? EDGES[$urandom_range(0, 4)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? EDGES[$urandom_range(0, 4)] : $urandom();
      sel = ($urandom_range(0, 7) == 0) ? 3'b111 : R_SEL[idx];
      kill = -1;
      if ((R_OPS[idx] == EXE_MULT_OP || R_OPS[idx] == EXE_MULTU_OP) && $urandom_range(0, 3) == 0)
        kill = $urandom_range(0, 32);
      issue(R_OPS[idx], sel, a, b, $urandom(), 1'($urandom_range(0, 1)), kill, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    ins_valid = 1'b0; aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
